// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage (EX -> MS -> WB)
//
// Holds one instruction from EX. A load or store whose data-SRAM request was
// already accepted in EX waits here for its data_ok response. Load data is
// then aligned and sign- or zero-extended, and the instruction is passed to
// write-back on ms_to_ws_bus. The stage also produces the forwarding and stall
// information that decode needs. Responses that belong to flushed requests
// are dropped by a small discard counter.
//
// Optional build macro: MEM_DATA_BYPASS_EN
//   defined   : a load completes in its data_ok cycle, and the result comes
//               straight from data_sram_rdata.
//   undefined : the response is first captured in rdata_buf. The load
//               completes one cycle after data_ok.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   ms_allowin          out MS can accept an instruction from EX this cycle
//   es_to_ms_valid/_bus in  EX instruction handshake and payload (131 bits)
//   es_req_inflight     in  EX holds an accepted request that has not yet
//                           been passed to MS
//   ws_allowin          in  WB can accept
//   ms_to_ws_valid/_bus out payload to WB (126 bits)
//   flush               in  exception/ertn flush from WB
//   data_sram_data_ok   in  response strobe (in order, one per request)
//   data_sram_rdata     in  response data
//   ms_fwd_*            out forwarding info for decode
//   ms_has_excp         out an exception or ertn sits in MS; EX must not
//                           issue new memory requests
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int DISCARD_CNT_W = 2
) (
  input  logic         clk,
  input  logic         reset,
  output logic         ms_allowin,
  input  logic         es_to_ms_valid,
  input  logic [130:0] es_to_ms_bus,
  input  logic         es_req_inflight,
  input  logic         ws_allowin,
  output logic         ms_to_ws_valid,
  output logic [125:0] ms_to_ws_bus,
  input  logic         flush,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  output logic         ms_fwd_valid,
  output logic [4:0]   ms_fwd_dest,
  output logic [31:0]  ms_fwd_data,
  output logic         ms_fwd_load_pending,
  output logic         ms_has_excp
);

  // Aligns and extends a raw response word to the load width.
  function automatic logic [31:0] ld_ext(input logic [2:0]  op,
                                         input logic [1:0]  lane,
                                         input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lane[1] ? d[31:16] : d[15:0];
    case (op)
      3'b001:  ld_ext = {{24{b[7]}}, b};
      3'b010:  ld_ext = {{16{h[15]}}, h};
      3'b011:  ld_ext = {24'b0, b};
      3'b100:  ld_ext = {16'b0, h};
      default: ld_ext = d;
    endcase
  endfunction

  logic                     ms_valid_q, ms_valid_d;
  logic [130:0]             bus_q;
  logic                     got_data_q, got_data_d;
  logic [DISCARD_CNT_W-1:0] discard_cnt_q, discard_cnt_d;
  logic [31:0]              rdata_buf_q, rdata_buf_d;

  // Decoded fields of the held instruction
  logic [2:0]  ld_op;
  logic        is_load, mem_req, csr_we, ertn, excp, gr_we;
  logic [6:0]  excp_num;
  logic [13:0] csr_idx;
  logic [31:0] csr_result, alu_result, pc;
  logic [4:0]  dest;

  assign ld_op      = bus_q[130:128];
  assign is_load    = bus_q[127];
  assign mem_req    = bus_q[126];
  assign excp_num   = bus_q[125:119];
  assign csr_we     = bus_q[118];
  assign csr_idx    = bus_q[117:104];
  assign csr_result = bus_q[103:72];
  assign ertn       = bus_q[71];
  assign excp       = bus_q[70];
  assign gr_we      = bus_q[69];
  assign dest       = bus_q[68:64];
  assign alu_result = bus_q[63:32];
  assign pc         = bus_q[31:0];

  logic        need_data, cnt_zero, resp_discard, resp_accept;
  logic        data_avail, ms_ready_go;
  logic [31:0] load_raw, final_result;
  logic [DISCARD_CNT_W:0] cnt_sum;

  assign need_data = mem_req & ~excp;
  assign cnt_zero  = (discard_cnt_q == '0);

  // While the discard counter is non-zero, every response belongs to an
  // older, flushed request.
  assign resp_discard = data_sram_data_ok & ~cnt_zero;
  assign resp_accept  = data_sram_data_ok & cnt_zero & ms_valid_q
                        & need_data & ~got_data_q;

`ifdef MEM_DATA_BYPASS_EN
  assign data_avail = got_data_q | (data_sram_data_ok & cnt_zero);
  assign load_raw   = got_data_q ? rdata_buf_q : data_sram_rdata;
`else
  assign data_avail = got_data_q;
  assign load_raw   = rdata_buf_q;
`endif

  assign ms_ready_go    = ~need_data | data_avail;
  assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go & ~flush;

  assign final_result = (is_load & ~excp) ? ld_ext(ld_op, alu_result[1:0], load_raw)
                                          : alu_result;

  assign ms_to_ws_bus = {excp_num, csr_we, csr_idx, csr_result, ertn, excp,
                         gr_we, dest, final_result, pc};

  assign ms_fwd_valid        = ms_valid_q & gr_we;
  assign ms_fwd_dest         = dest;
  assign ms_fwd_data         = final_result;
  assign ms_fwd_load_pending = ms_valid_q & is_load & need_data & ~data_avail;
  assign ms_has_excp         = ms_valid_q & (excp | ertn);

  always_comb begin
    ms_valid_d    = ms_valid_q;
    got_data_d    = got_data_q;
    rdata_buf_d   = rdata_buf_q;
    discard_cnt_d = discard_cnt_q;
    cnt_sum       = '0;

    if (flush)           ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = es_to_ms_valid;

    if (flush | ms_allowin) got_data_d = 1'b0;
    else if (resp_accept)   got_data_d = 1'b1;

    if (resp_accept) rdata_buf_d = data_sram_rdata;

    // On flush, a still-outstanding response of the held instruction and the
    // one EX has in flight must both be dropped later. A response accepted in
    // the flush cycle is already home and is not counted.
    cnt_sum = {1'b0, discard_cnt_q}
            + {{DISCARD_CNT_W{1'b0}},
               flush & ms_valid_q & need_data & ~got_data_q & ~resp_accept}
            + {{DISCARD_CNT_W{1'b0}}, flush & es_req_inflight}
            - {{DISCARD_CNT_W{1'b0}}, resp_discard};
    discard_cnt_d = cnt_sum[DISCARD_CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q    <= 1'b0;
      got_data_q    <= 1'b0;
      discard_cnt_q <= '0;
      rdata_buf_q   <= '0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      got_data_q    <= got_data_d;
      discard_cnt_q <= discard_cnt_d;
      rdata_buf_q   <= rdata_buf_d;
    end
  end

  // Payload register is not reset; ms_valid_q qualifies it.
  always_ff @(posedge clk) begin
    if (es_to_ms_valid & ms_allowin) bus_q <= es_to_ms_bus;
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [130:0] es_to_ms_bus;
  logic         es_req_inflight;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [125:0] ms_to_ws_bus;
  logic         flush;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ms_fwd_valid;
  logic [4:0]   ms_fwd_dest;
  logic [31:0]  ms_fwd_data;
  logic         ms_fwd_load_pending;
  logic         ms_has_excp;

  int n_vec = 0;
  int n_err = 0;

  mem_stage #(.DISCARD_CNT_W(2)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ms_allowin          (ms_allowin),
    .es_to_ms_valid      (es_to_ms_valid),
    .es_to_ms_bus        (es_to_ms_bus),
    .es_req_inflight     (es_req_inflight),
    .ws_allowin          (ws_allowin),
    .ms_to_ws_valid      (ms_to_ws_valid),
    .ms_to_ws_bus        (ms_to_ws_bus),
    .flush               (flush),
    .data_sram_data_ok   (data_sram_data_ok),
    .data_sram_rdata     (data_sram_rdata),
    .ms_fwd_valid        (ms_fwd_valid),
    .ms_fwd_dest         (ms_fwd_dest),
    .ms_fwd_data         (ms_fwd_data),
    .ms_fwd_load_pending (ms_fwd_load_pending),
    .ms_has_excp         (ms_has_excp)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [130:0] mk(input logic [2:0] op, input logic ld,
                                      input logic mreq, input logic [6:0] enm,
                                      input logic ex, input logic gw,
                                      input logic [4:0] dst, input logic [31:0] alu,
                                      input logic [31:0] pcv);
    mk = {op, ld, mreq, enm, 1'b0, 14'h0, 32'h0, 1'b0, ex, gw, dst, alu, pcv};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a load/store from data_ok onward and check it leaves MS.
  task automatic finish_load(input logic [31:0] rd, input logic [31:0] exp, input string tag);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    @(negedge clk);
`ifdef MEM_DATA_BYPASS_EN
    chk1({tag, "_vld"}, ms_to_ws_valid, 1'b1);
    chk32({tag, "_res"}, ms_to_ws_bus[63:32], exp);
    chk32({tag, "_fwd"}, ms_fwd_data, exp);
    chk1({tag, "_pend"}, ms_fwd_load_pending, 1'b0);
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEADBEEF;
`else
    chk1({tag, "_vld_dok"}, ms_to_ws_valid, 1'b0);
    chk1({tag, "_pend_dok"}, ms_fwd_load_pending, 1'b1);
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEADBEEF;
    @(negedge clk);
    chk1({tag, "_vld"}, ms_to_ws_valid, 1'b1);
    chk32({tag, "_res"}, ms_to_ws_bus[63:32], exp);
    chk32({tag, "_fwd"}, ms_fwd_data, exp);
    chk1({tag, "_pend"}, ms_fwd_load_pending, 1'b0);
    cyc();
`endif
    @(negedge clk);
    chk1({tag, "_gone"}, ms_to_ws_valid, 1'b0);
  endtask

  task automatic enter(input logic [130:0] b);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    cyc();
    es_to_ms_valid = 1'b0;
  endtask

  task automatic run_load(input logic [130:0] b, input int gap, input logic [31:0] rd,
                          input logic [31:0] exp, input string tag);
    enter(b);
    for (int i = 1; i < gap; i++) begin
      @(negedge clk);
      chk1({tag, "_wait"}, ms_to_ws_valid, 1'b0);
      cyc();
    end
    finish_load(rd, exp, tag);
  endtask

  initial begin
    reset = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    es_req_inflight = 1'b0;
    ws_allowin = 1'b1;
    flush = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;

    // Reset state
    #2;
    chk1("rst_vld", ms_to_ws_valid, 1'b0);
    chk1("rst_pend", ms_fwd_load_pending, 1'b0);
    chk1("rst_fwdv", ms_fwd_valid, 1'b0);
    chk1("rst_excp", ms_has_excp, 1'b0);
    chk1("rst_allowin", ms_allowin, 1'b1);
    cyc();
    cyc();
    @(negedge clk);
    reset = 1'b0;
    chk32("rst_cnt", {30'b0, dut.discard_cnt_q}, 32'd0);

    // ld.w, data_ok three cycles after entry
    enter(mk(3'b000, 1'b1, 1'b1, 7'h0, 1'b0, 1'b1, 5'd4, 32'h0000_1000, 32'h8000_0000));
    @(negedge clk);
    chk1("ldw_wait1", ms_to_ws_valid, 1'b0);
    chk1("ldw_pend1", ms_fwd_load_pending, 1'b1);
    chk1("ldw_fwdv", ms_fwd_valid, 1'b1);
    chk32("ldw_dest", {27'b0, ms_fwd_dest}, 32'd4);
    chk1("ldw_allowin", ms_allowin, 1'b0);
    cyc();
    @(negedge clk);
    chk1("ldw_wait2", ms_to_ws_valid, 1'b0);
    cyc();
    finish_load(32'h89AB_CDEF, 32'h89AB_CDEF, "ldw");

    // Sub-word loads on rdata 0x80FF7F01
    run_load(mk(3'b001, 1'b1, 1'b1, 7'h0, 1'b0, 1'b1, 5'd5, 32'h0000_2003, 32'h8000_0004),
             1, 32'h80FF_7F01, 32'hFFFF_FF80, "ldb");
    run_load(mk(3'b011, 1'b1, 1'b1, 7'h0, 1'b0, 1'b1, 5'd6, 32'h0000_2003, 32'h8000_0008),
             1, 32'h80FF_7F01, 32'h0000_0080, "ldbu");
    run_load(mk(3'b010, 1'b1, 1'b1, 7'h0, 1'b0, 1'b1, 5'd7, 32'h0000_2002, 32'h8000_000C),
             2, 32'h80FF_7F01, 32'hFFFF_80FF, "ldh");
    run_load(mk(3'b100, 1'b1, 1'b1, 7'h0, 1'b0, 1'b1, 5'd8, 32'h0000_2002, 32'h8000_0010),
             1, 32'h80FF_7F01, 32'h0000_80FF, "ldhu");
    run_load(mk(3'b001, 1'b1, 1'b1, 7'h0, 1'b0, 1'b1, 5'd8, 32'h0000_2001, 32'h8000_0014),
             1, 32'h80FF_7F01, 32'h0000_007F, "ldb1");

    // Flush while a load waits and EX has a request in flight
    enter(mk(3'b000, 1'b1, 1'b1, 7'h0, 1'b0, 1'b1, 5'd9, 32'h0000_3000, 32'h8000_0020));
    @(negedge clk);
    chk1("fl_pend", ms_fwd_load_pending, 1'b1);
    flush = 1'b1;
    es_req_inflight = 1'b1;
    #1;
    chk1("fl_vld", ms_to_ws_valid, 1'b0);
    cyc();
    flush = 1'b0;
    es_req_inflight = 1'b0;
    @(negedge clk);
    chk32("fl_cnt2", {30'b0, dut.discard_cnt_q}, 32'd2);
    chk1("fl_fwdv", ms_fwd_valid, 1'b0);
    chk1("fl_allowin", ms_allowin, 1'b1);
    // New load enters together with the first stale response
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b000, 1'b1, 1'b1, 7'h0, 1'b0, 1'b1, 5'd10, 32'h0000_3004, 32'h8000_0024);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1111_1111;
    cyc();
    es_to_ms_valid = 1'b0;
    data_sram_rdata = 32'h2222_2222;
    @(negedge clk);
    chk1("fl_stale2_vld", ms_to_ws_valid, 1'b0);
    chk1("fl_stale2_pend", ms_fwd_load_pending, 1'b1);
    cyc();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    chk32("fl_cnt0", {30'b0, dut.discard_cnt_q}, 32'd0);
    chk1("fl_still_wait", ms_to_ws_valid, 1'b0);
    cyc();
    finish_load(32'h0000_ABCD, 32'h0000_ABCD, "fl_new");

    // Exception instruction never waits
    enter(mk(3'b000, 1'b1, 1'b1, 7'b1000000, 1'b1, 1'b0, 5'd0, 32'h0000_4444, 32'h8000_0030));
    @(negedge clk);
    chk1("ex_vld", ms_to_ws_valid, 1'b1);
    chk1("ex_has", ms_has_excp, 1'b1);
    chk1("ex_pend", ms_fwd_load_pending, 1'b0);
    chk32("ex_num", {25'b0, ms_to_ws_bus[125:119]}, 32'h0000_0040);
    chk32("ex_res", ms_to_ws_bus[63:32], 32'h0000_4444);
    chk32("ex_pc", ms_to_ws_bus[31:0], 32'h8000_0030);
    cyc();
    @(negedge clk);
    chk1("ex_gone", ms_to_ws_valid, 1'b0);
    chk1("ex_has_gone", ms_has_excp, 1'b0);

    // WB stall holds the loaded data
    enter(mk(3'b010, 1'b1, 1'b1, 7'h0, 1'b0, 1'b1, 5'd11, 32'h0000_5000, 32'h8000_0040));
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0000_FFFE;
    @(negedge clk);
`ifdef MEM_DATA_BYPASS_EN
    chk1("st_dok_vld", ms_to_ws_valid, 1'b1);
`else
    chk1("st_dok_vld", ms_to_ws_valid, 1'b0);
`endif
    chk1("st_dok_allowin", ms_allowin, 1'b0);
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h5555_AAAA;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("st_hold_vld", ms_to_ws_valid, 1'b1);
      chk32("st_hold_res", ms_to_ws_bus[63:32], 32'hFFFF_FFFE);
      chk1("st_hold_allowin", ms_allowin, 1'b0);
      if (k < 3) cyc();
    end
    ws_allowin = 1'b1;
    #1;
    chk1("st_rel_vld", ms_to_ws_valid, 1'b1);
    chk1("st_rel_allowin", ms_allowin, 1'b1);
    chk32("st_rel_res", ms_to_ws_bus[63:32], 32'hFFFF_FFFE);
    cyc();
    @(negedge clk);
    chk1("st_gone", ms_to_ws_valid, 1'b0);

    // Reset while a load waits and stale responses are owed
    enter(mk(3'b000, 1'b1, 1'b1, 7'h0, 1'b0, 1'b1, 5'd12, 32'h0000_6000, 32'h8000_0050));
    flush = 1'b1;
    es_req_inflight = 1'b1;
    cyc();
    flush = 1'b0;
    es_req_inflight = 1'b0;
    enter(mk(3'b000, 1'b1, 1'b1, 7'h0, 1'b0, 1'b1, 5'd13, 32'h0000_6004, 32'h8000_0054));
    @(negedge clk);
    chk1("ar_pend_before", ms_fwd_load_pending, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk1("ar_vld", ms_to_ws_valid, 1'b0);
    chk1("ar_pend", ms_fwd_load_pending, 1'b0);
    chk1("ar_fwdv", ms_fwd_valid, 1'b0);
    chk1("ar_excp", ms_has_excp, 1'b0);
    cyc();
    @(negedge clk);
    reset = 1'b0;
    chk32("ar_cnt", {30'b0, dut.discard_cnt_q}, 32'd0);
    run_load(mk(3'b000, 1'b1, 1'b1, 7'h0, 1'b0, 1'b1, 5'd14, 32'h0000_6008, 32'h8000_0058),
             2, 32'h1357_9BDF, 32'h1357_9BDF, "ar_ld");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and the write-back stage.
- Accepts an EX-stage instruction and, for loads/stores whose data-SRAM request was already accepted in EX, waits for the `data_ok` response.
- Aligns and extends load data, then presents the 126-bit `ms_to_ws_bus` consumed by write-back.
- Owns forwarding/stall info for decode and discards responses belonging to flushed requests.

Parameters:
- DISCARD_CNT_W, 2, width of the flushed-response discard counter; max count 2^W−1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ms_allowin  out  1  MS can accept from EX this cycle
- es_to_ms_valid  in  1  EX presents a valid instruction
- es_to_ms_bus  in  131  {ld_op[130:128], is_load[127], mem_req[126], excp_num[125:119], csr_we[118], csr_idx[117:104], csr_result[103:72], ertn[71], excp[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
- es_req_inflight  in  1  EX holds an addr_ok-accepted request not yet passed to MS
- ws_allowin  in  1  WB can accept
- ms_to_ws_valid  out  1  MS output valid
- ms_to_ws_bus  out  126  {excp_num, csr_we, csr_idx, csr_result, ertn, excp, gr_we, dest, final_result, pc}
- flush  in  1  excp_flush | ertn_flush from WB
- data_sram_data_ok  in  1  data response valid (one per accepted request, in order)
- data_sram_rdata  in  32  response data
- ms_fwd_valid  out  1  ms_valid & gr_we
- ms_fwd_dest  out  5  destination register
- ms_fwd_data  out  32  final_result as currently known
- ms_fwd_load_pending  out  1  ms_valid & is_load & data not yet available; decode must stall
- ms_has_excp  out  1  ms_valid & (excp | ertn); EX must not issue new memory requests

Behaviour:
- Reset: ms_valid=0, got_data=0, discard_cnt=0, rdata_buf=0; all valid/pending outputs 0; bus register contents don't-care.
- Registers:
  - ms_valid clears on reset or flush; otherwise loads es_to_ms_valid when ms_allowin.
  - bus_r captures es_to_ms_bus when es_to_ms_valid & ms_allowin.
- need_data = mem_req & ~excp.
- ms_ready_go = ~need_data | data_avail. ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin). ms_to_ws_valid = ms_valid & ms_ready_go & ~flush.
- Response handling, in order:
  - If discard_cnt≠0, data_ok decrements the counter and is otherwise ignored.
  - Else, if ms_valid & need_data & ~got_data, data_ok captures rdata into rdata_buf and sets got_data.
  - Else data_ok is a protocol error; the bench asserts it never occurs.
- got_data clears when the instruction leaves (ms_allowin), on flush, or on reset.
- Flush: discard_cnt += (ms_valid & need_data & ~got_data & ~data_ok_this_cycle) + es_req_inflight.
  - Simultaneous decrement in the same cycle nets out.
  - The counter never exceeds 2 by protocol; overflow is an assertion failure.
- Load extension, addr = alu_result, byte lane = addr[1:0]:
  - ld_op 000 W: whole word.
  - 001 B: sign-extend byte[lane].
  - 010 H: sign-extend half[addr[1]].
  - 011 BU: zero-extend byte[lane].
  - 100 HU: zero-extend half[addr[1]].
  - Other encodings: word.
- final_result = is_load & ~excp ? extended data : alu_result. Stores pass alu_result with gr_we=0 and still wait for data_ok.
- Exceptions (excp=1) never wait. excp_num, csr fields, ertn and pc pass through unchanged.
- WB stall holding data: got_data persists until transfer, and the output stays stable.

Optional Feature:
- MEM_DATA_BYPASS_EN. Defined: data_avail = got_data | (data_ok & discard_cnt==0). The load completes in the data_ok cycle, with final_result and ms_fwd_data taken directly from extended data_sram_rdata.
- Undefined: data_avail = got_data only. There is one extra cycle after data_ok, and output comes from rdata_buf. ms_fwd_load_pending stays high through the data_ok cycle.

Test Plan:
- ld.w, addr 0x1000, data_ok 3 cycles after entry with rdata 0x89ABCDEF -> ms_to_ws_valid rises with final_result 0x89ABCDEF; the cycle it rises depends on MEM_DATA_BYPASS_EN (data_ok cycle if defined, next cycle if not).
- ld.b / ld.bu / ld.h / ld.hu, addr[1:0]=3/3/2/2, rdata 0x80FF7F01 -> final_result 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF.
- Load waiting, flush asserted with es_req_inflight=1 -> discard_cnt=2. Next two data_ok are ignored; a new load's data_ok then completes normally.
- Instruction with excp=1, excp_num=7'b1000000, mem_req=1 -> passes in 1 cycle without waiting; ms_has_excp=1.
- ws_allowin=0 for 4 cycles after data_ok on ld.h rdata 0x0000FFFE addr 0 -> output held at 0xFFFFFFFE; transfers on release; ms_allowin low meanwhile.
- Assert reset while a load waits -> all outputs 0 immediately; discard_cnt=0 after release.
